// File: rtl/rupt_sequencer_pkg.sv
// Shared types and constants for the RUPT sequencer: FSM states, named
// interrupt sources and default vector placement.
package rupt_sequencer_pkg;

    typedef enum logic [1:0] {IDLE, SAVE, VECTOR, ISR} rupt_state_t;

    localparam int T6RUPT   = 0;
    localparam int T5RUPT   = 1;
    localparam int T3RUPT   = 2;
    localparam int T4RUPT   = 3;
    localparam int KEYRUPT1 = 4;
    localparam int KEYRUPT2 = 5;
    localparam int UPRUPT   = 6;
    localparam int DOWNRUPT = 7;
    localparam int RADARUPT = 8;
    localparam int HANDRUPT = 9;

    localparam logic [11:0] DEF_VEC_BASE   = 12'o4004;
    localparam int          DEF_VEC_STRIDE = 4;

    // Vector address wraps in the 12-bit address space.
    function automatic logic [11:0] vec_addr(input logic [11:0] base, input int stride,
                                             input int idx);
        return base + 12'(stride * idx);
    endfunction

endpackage

// File: rtl/rupt_sequencer_prio_enc.sv
// Combinational lowest-index-first priority encoder for latched RUPT requests.
module rupt_prio_enc #(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     pend,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) idx = IDX_W'(i);
        end
    end

    assign any = |pend;

endmodule

// File: rtl/rupt_sequencer.sv
// AGC interrupt sequencer: latches request edges, accepts at instruction
// boundaries, sequences SAVE/VECTOR/ISR. Optional lock alarm: RUPT_LOCK_TIMER_EN.
module rupt_sequencer
    import rupt_sequencer_pkg::*;
#(
    parameter int          NUM_RUPT   = 10,
    parameter logic [11:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int          VEC_STRIDE = DEF_VEC_STRIDE,
    parameter logic [15:0] LOCK_LIMIT = 16'd4096
) (
    input  logic                clock,
    input  logic                rst_l,
    input  logic [NUM_RUPT-1:0] rupt_req,
    input  logic                inhint,
    input  logic                relint,
    input  logic                resume,
    input  logic                ext_pending,
    input  logic                branch_D,
    input  logic                ovf_a,
    input  logic [11:0]         pc,
    output logic                rupt_flush,
    output logic                save_pc_en,
    output logic [11:0]         save_pc,
    output logic                vec_valid,
    output logic [11:0]         rupt_vec,
    output logic                in_rupt,
    output logic [NUM_RUPT-1:0] rupt_pending,
    output logic                rupt_lock
);

    localparam int IDX_W = (NUM_RUPT > 1) ? $clog2(NUM_RUPT) : 1;

    rupt_state_t         state, state_nxt;
    logic [NUM_RUPT-1:0] pend, hist, rise, grant;
    logic                en, any, accept;
    logic [IDX_W-1:0]    enc_idx, win_idx;
    logic [11:0]         ret_pc;

    rupt_prio_enc #(.N(NUM_RUPT), .IDX_W(IDX_W)) u_enc (
        .pend (pend),
        .any  (any),
        .idx  (enc_idx)
    );

    assign rise   = rupt_req & ~hist;
    assign accept = (state == IDLE) & any & en & ~ext_pending & ~branch_D & ~ovf_a;
    assign grant  = accept ? ({{(NUM_RUPT-1){1'b0}}, 1'b1} << enc_idx) : '0;

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state   <= IDLE;
            hist    <= '0;
            pend    <= '0;
            en      <= 1'b1;
            win_idx <= '0;
            ret_pc  <= '0;
        end else begin
            state <= state_nxt;
            hist  <= rupt_req;
            // A fresh edge on the granted line re-arms it.
            pend  <= (pend & ~grant) | rise;
            if (inhint)      en <= 1'b0;
            else if (relint) en <= 1'b1;
            if (accept) begin
                win_idx <= enc_idx;
                ret_pc  <= pc + 12'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rupt_flush = 1'b0;
        save_pc_en = 1'b0;
        save_pc    = '0;
        vec_valid  = 1'b0;
        rupt_vec   = '0;
        in_rupt    = 1'b0;
        case (state)
            IDLE:   if (accept) state_nxt = SAVE;
            SAVE: begin
                rupt_flush = 1'b1;
                save_pc_en = 1'b1;
                save_pc    = ret_pc;
                state_nxt  = VECTOR;
            end
            VECTOR: begin
                vec_valid  = 1'b1;
                rupt_flush = 1'b1;
                rupt_vec   = vec_addr(VEC_BASE, VEC_STRIDE, int'(win_idx));
                state_nxt  = ISR;
            end
            ISR: begin
                in_rupt = 1'b1;
                if (resume) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rupt_pending = pend;

`ifdef RUPT_LOCK_TIMER_EN
    logic [15:0] lock_cnt;
    logic        lock_q;

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            lock_cnt <= '0;
            lock_q   <= 1'b0;
        end else begin
            if (state == ISR) begin
                if (lock_cnt != 16'hFFFF) lock_cnt <= lock_cnt + 16'd1;
            end else begin
                lock_cnt <= '0;
            end
            if ((state == ISR) && (lock_cnt == LOCK_LIMIT)) lock_q <= 1'b1;
        end
    end

    assign rupt_lock = lock_q;
`else
    logic unused_lock_limit;
    assign unused_lock_limit = ^LOCK_LIMIT;
    assign rupt_lock = 1'b0;
`endif

endmodule

// File: tb/tb_rupt_sequencer.sv
// Directed self-checking bench for rupt_sequencer: table of single-source
// interrupts plus hand-written sequences for priority, inhibit, boundary and reset.
module tb_rupt_sequencer;

    logic        clock = 1'b0;
    logic        rst_l;
    logic [9:0]  rupt_req;
    logic        inhint, relint, resume, ext_pending, branch_D, ovf_a;
    logic [11:0] pc;
    logic        rupt_flush, save_pc_en, vec_valid, in_rupt, rupt_lock;
    logic [11:0] save_pc, rupt_vec;
    logic [9:0]  rupt_pending;

    int n_chk  = 0;
    int n_fail = 0;

    rupt_sequencer #(.LOCK_LIMIT(16'd8)) dut (
        .clock        (clock),
        .rst_l        (rst_l),
        .rupt_req     (rupt_req),
        .inhint       (inhint),
        .relint       (relint),
        .resume       (resume),
        .ext_pending  (ext_pending),
        .branch_D     (branch_D),
        .ovf_a        (ovf_a),
        .pc           (pc),
        .rupt_flush   (rupt_flush),
        .save_pc_en   (save_pc_en),
        .save_pc      (save_pc),
        .vec_valid    (vec_valid),
        .rupt_vec     (rupt_vec),
        .in_rupt      (in_rupt),
        .rupt_pending (rupt_pending),
        .rupt_lock    (rupt_lock)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          src;
        logic [11:0] pc;
        logic [11:0] exp_save;
        logic [11:0] exp_vec;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // From the SAVE cycle onward: expect VECTOR, ISR, then resume back to IDLE.
    task automatic finish_vec(input string nm, input logic [11:0] exp_vec);
        step();
        chk({nm, " vec_valid"}, vec_valid, 1);
        chk({nm, " rupt_vec"}, rupt_vec, exp_vec);
        step();
        chk({nm, " in_rupt"}, in_rupt, 1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk({nm, " resume"}, in_rupt, 0);
    endtask

    task automatic pulse_req(input int src);
        rupt_req = '0;
        rupt_req[src] = 1'b1;
        step();
        rupt_req = '0;
    endtask

    initial begin
        tbl[0] = '{2, 12'o2100, 12'o2101, 12'o4014};
        tbl[1] = '{0, 12'o7777, 12'o0000, 12'o4004};
        tbl[2] = '{9, 12'o0000, 12'o0001, 12'o4050};
        tbl[3] = '{5, 12'o1234, 12'o1235, 12'o4030};
        tbl[4] = '{7, 12'o3776, 12'o3777, 12'o4040};

        rst_l = 1'b0; rupt_req = '0; inhint = 0; relint = 0; resume = 0;
        ext_pending = 0; branch_D = 0; ovf_a = 0; pc = 12'o2100;
        #12;
        chk("reset flush", rupt_flush, 0);
        chk("reset save_pc", {save_pc_en, save_pc}, 0);
        chk("reset vec", {vec_valid, rupt_vec}, 0);
        chk("reset in_rupt", in_rupt, 0);
        chk("reset pending", rupt_pending, 0);
        chk("reset lock", rupt_lock, 0);
        rst_l = 1'b1;
        step();

        // Single-source table
        for (int k = 0; k < 5; k++) begin
            pc = tbl[k].pc;
            pulse_req(tbl[k].src);
            chk($sformatf("t%0d pend", k), rupt_pending, 32'(1) << tbl[k].src);
            chk($sformatf("t%0d idle", k), rupt_flush, 0);
            step();
            chk($sformatf("t%0d save flush", k), {rupt_flush, save_pc_en}, 2'b11);
            chk($sformatf("t%0d save_pc", k), save_pc, tbl[k].exp_save);
            chk($sformatf("t%0d pend clr", k), rupt_pending, 0);
            finish_vec($sformatf("t%0d", k), tbl[k].exp_vec);
        end
        pc = 12'o2100;

        // Simultaneous requests: source 1 first, source 5 after resume
        rupt_req = 10'b00_0010_0010;
        step();
        rupt_req = '0;
        chk("dual pend", rupt_pending, 10'b00_0010_0010);
        step();
        chk("dual save", rupt_flush, 1);
        chk("dual pend5", rupt_pending, 10'b00_0010_0000);
        step();
        chk("dual vec1", rupt_vec, 12'o4010);
        step();
        step();
        chk("dual no nest", {in_rupt, rupt_flush}, 2'b10);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("dual idle", {in_rupt, rupt_flush}, 2'b00);
        step();
        chk("dual save2", save_pc_en, 1);
        finish_vec("dual second", 12'o4030);

        // Boundary blockers: ext_pending, branch_D, ovf_a
        for (int b = 0; b < 3; b++) begin
            {ovf_a, branch_D, ext_pending} = 3'(1 << b);
            pulse_req(0);
            for (int c = 0; c < 3; c++) begin
                step();
                chk($sformatf("blk%0d hold", b), rupt_flush, 0);
            end
            {ovf_a, branch_D, ext_pending} = 3'b000;
            step();
            chk($sformatf("blk%0d save", b), save_pc_en, 1);
            finish_vec($sformatf("blk%0d", b), 12'o4004);
        end

        // Inhibit, request, relint ten cycles later
        inhint = 1'b1;
        step();
        inhint = 1'b0;
        pulse_req(0);
        for (int c = 0; c < 9; c++) begin
            step();
            chk("inh hold", rupt_flush, 0);
        end
        chk("inh pend", rupt_pending, 1);
        relint = 1'b1;
        step();
        relint = 1'b0;
        chk("relint edge", rupt_flush, 0);
        step();
        chk("relint save", save_pc_en, 1);
        finish_vec("relint", 12'o4004);

        // inhint and relint together leave interrupts disabled
        inhint = 1'b1; relint = 1'b1;
        step();
        inhint = 1'b0; relint = 1'b0;
        pulse_req(3);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("both hold", rupt_flush, 0);
        end
        relint = 1'b1;
        step();
        relint = 1'b0;
        step();
        chk("both save", save_pc_en, 1);
        finish_vec("both", 12'o4020);

        // resume outside ISR does nothing
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("stray resume", {in_rupt, rupt_flush, vec_valid}, 0);

`ifdef RUPT_LOCK_TIMER_EN
        pulse_req(0);
        step();
        step();
        step();
        chk("lock early", rupt_lock, 0);
        for (int c = 0; c < 10; c++) step();
        chk("lock set", rupt_lock, 1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();
        chk("lock sticky", rupt_lock, 1);
`endif

        // Reset while in ISR with another request pending
        pulse_req(0);
        step();
        step();
        step();
        chk("rst pre isr", in_rupt, 1);
        pulse_req(3);
        chk("rst pre pend", rupt_pending, 10'b00_0000_1000);
        rst_l = 1'b0;
        #1;
        chk("rst async in_rupt", in_rupt, 0);
        chk("rst async pend", rupt_pending, 0);
        chk("rst async lock", rupt_lock, 0);
        #2;
        rst_l = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("post rst quiet", {vec_valid, rupt_flush, in_rupt}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
